// File: rtl/ysyx_040729_div_pkg.sv
// Shared definitions for the iterative EXE-stage divider: FSM encoding and special-case fills.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ysyx_040729_div_pkg;

  // Divider FSM state encoding (3 bits)
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PREP  = 3'd1,
    CALC  = 3'd2,
    FIXUP = 3'd3,
    DONE  = 3'd4
  } div_state_e;

  // Divide-by-zero returns an all-ones quotient; replicate this bit across XLEN.
  localparam logic DIV0_QUOT_FILL = 1'b1;
  // Signed overflow (most-negative / -1) returns a zero remainder; replicate across XLEN.
  localparam logic OVF_REM_FILL   = 1'b0;

endpackage

// File: rtl/ysyx_040729_exe_alu_div_step.sv
// One restoring division step: shift in a dividend bit, trial-subtract the divisor, keep or restore.
// Latency: purely combinational.
// Backpressure: none; chained by the iterative top level.
module ysyx_040729_exe_alu_div_step
  import ysyx_040729_div_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN:0]   rem_i,
  input  logic            dvd_bit_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN:0]   rem_o,
  output logic            q_bit_o
);

  logic [XLEN+1:0] shifted;
  logic [XLEN+1:0] diff;

  // Trial subtract one bit wider than the partial remainder; the top bit is the borrow.
  always_comb begin
    shifted = {rem_i, dvd_bit_i};
    diff    = shifted - {2'b00, divisor_i};
    q_bit_o = ~diff[XLEN+1];
    rem_o   = q_bit_o ? diff[XLEN:0] : shifted[XLEN:0];
  end

endmodule

// File: rtl/ysyx_040729_exe_alu_div_iter.sv
// Iterative restoring divider (RV64M DIV/DIVU/REM/REMU and W forms); optional YSYX_040729_DIV_EARLY_OUT_EN.
// Latency: N+3 cycles counting the accept edge (N = XLEN/ITER_PER_CYCLE, halved for W); special cases 2; early-out 3.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready; flush aborts from any state.
module ysyx_040729_exe_alu_div_iter
  import ysyx_040729_div_pkg::*;
#(
  parameter int XLEN           = 64,
  parameter int ITER_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            is_signed,
  input  logic            is_word,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int HALF  = XLEN / 2;
  localparam int CNT_W = $clog2(XLEN);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  dvd_q, dvd_d;       // width-adjusted dividend
  logic [XLEN-1:0]  dvs_q, dvs_d;       // width-adjusted divisor
  logic             sgn_q, sgn_d;
  logic             word_q, word_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic [XLEN-1:0]  quot_q, quot_d;     // dividend shifter / quotient accumulator
  logic [XLEN:0]    rem_q, rem_d;       // partial remainder, one guard bit
  logic [XLEN-1:0]  dvs_mag_q, dvs_mag_d;

  // Operand decode used in PREP
  logic             dvd_neg, dvs_neg;
  logic [XLEN-1:0]  dvd_mag, dvs_mag;
  logic [XLEN-1:0]  min_neg;
  logic             dvs_zero, ovf;
  logic [CNT_W-1:0] cnt_last;

  // Restoring step chain outputs
  logic [ITER_PER_CYCLE-1:0] qbits;
  logic [XLEN:0]             step_rem;

  // Sign-extend from bit HALF-1 when in word mode
  function automatic logic [XLEN-1:0] fit_w(input logic [XLEN-1:0] v, input logic w);
    return w ? {{HALF{v[HALF-1]}}, v[HALF-1:0]} : v;
  endfunction

  // ITER_PER_CYCLE restoring steps per clock, MSB-first through the dividend shifter
  for (genvar i = 0; i < ITER_PER_CYCLE; i++) begin : g_step
    logic [XLEN:0] rem_in;
    logic [XLEN:0] rem_out;
    if (i == 0) begin : g_first
      assign rem_in = rem_q;
    end else begin : g_next
      assign rem_in = g_step[i-1].rem_out;
    end
    ysyx_040729_exe_alu_div_step #(.XLEN(XLEN)) u_step (
      .rem_i     (rem_in),
      .dvd_bit_i (quot_q[XLEN-1-i]),
      .divisor_i (dvs_mag_q),
      .rem_o     (rem_out),
      .q_bit_o   (qbits[ITER_PER_CYCLE-1-i])
    );
  end
  assign step_rem = g_step[ITER_PER_CYCLE-1].rem_out;

  // Magnitudes, result signs and special-case detection from the latched operands
  always_comb begin
    dvd_neg  = sgn_q & dvd_q[XLEN-1];
    dvs_neg  = sgn_q & dvs_q[XLEN-1];
    dvd_mag  = dvd_neg ? -dvd_q : dvd_q;
    dvs_mag  = dvs_neg ? -dvs_q : dvs_q;
    min_neg  = word_q ? {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
    dvs_zero = (dvs_q == '0);
    ovf      = sgn_q && (dvd_q == min_neg) && (dvs_q == '1);
    cnt_last = word_q ? CNT_W'(HALF / ITER_PER_CYCLE - 1) : CNT_W'(XLEN / ITER_PER_CYCLE - 1);
  end

  // Next-state and datapath updates; flush overrides everything and returns to IDLE
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    sgn_d     = sgn_q;
    word_d    = word_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    dvs_mag_d = dvs_mag_q;

    case (state_q)
      IDLE: begin
        if (in_valid && !flush) begin
          dvd_d   = is_word ? {{HALF{is_signed & dividend[HALF-1]}}, dividend[HALF-1:0]} : dividend;
          dvs_d   = is_word ? {{HALF{is_signed & divisor[HALF-1]}}, divisor[HALF-1:0]} : divisor;
          sgn_d   = is_signed;
          word_d  = is_word;
          state_d = PREP;
        end
      end
      PREP: begin
        q_neg_d = dvd_neg ^ dvs_neg;
        r_neg_d = dvd_neg;
        if (dvs_zero) begin
          quot_d  = {XLEN{DIV0_QUOT_FILL}};
          rem_d   = {1'b0, fit_w(dvd_q, word_q)};
          state_d = DONE;
        end else if (ovf) begin
          quot_d  = fit_w(dvd_q, word_q);
          rem_d   = {(XLEN+1){OVF_REM_FILL}};
          state_d = DONE;
`ifdef YSYX_040729_DIV_EARLY_OUT_EN
        end else if (dvd_mag < dvs_mag) begin
          // Quotient is zero; FIXUP restores the dividend sign on the remainder.
          quot_d  = '0;
          rem_d   = {1'b0, dvd_mag};
          state_d = FIXUP;
`endif
        end else begin
          // Word magnitudes fit in the low half; park them at the top so the shifter feeds MSB-first.
          quot_d    = word_q ? {dvd_mag[HALF-1:0], {HALF{1'b0}}} : dvd_mag;
          rem_d     = '0;
          dvs_mag_d = dvs_mag;
          cnt_d     = '0;
          state_d   = CALC;
        end
      end
      CALC: begin
        quot_d = {quot_q[XLEN-1-ITER_PER_CYCLE:0], qbits};
        rem_d  = step_rem;
        if (cnt_q == cnt_last) begin
          cnt_d   = '0;
          state_d = FIXUP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      FIXUP: begin
        quot_d  = fit_w(q_neg_q ? -quot_q : quot_q, word_q);
        rem_d   = {1'b0, fit_w(r_neg_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0], word_q)};
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      sgn_q     <= 1'b0;
      word_q    <= 1'b0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      quot_q    <= '0;
      rem_q     <= '0;
      dvs_mag_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      sgn_q     <= sgn_d;
      word_q    <= word_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      dvs_mag_q <= dvs_mag_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign quotient  = quot_q;
  assign remainder = rem_q[XLEN-1:0];

endmodule

// File: tb/tb_ysyx_040729_exe_alu_div_iter.sv
// Directed bench for the iterative divider: results, latency, handshakes, flush and async reset.
// Latency is counted in rising edges including the accept edge.
// Backpressure exercised by holding out_ready low in DONE.
module tb_ysyx_040729_exe_alu_div_iter;

  localparam int XLEN = 64;
  localparam int IPC  = 1;
  localparam int LAT_D = XLEN / IPC + 3;
  localparam int LAT_W = XLEN / 2 / IPC + 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            is_signed;
  logic            is_word;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] quotient;
  logic [XLEN-1:0] remainder;

  int n_checks = 0;
  int n_fail   = 0;

  ysyx_040729_exe_alu_div_iter #(.XLEN(XLEN), .ITER_PER_CYCLE(IPC)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .is_signed (is_signed),
    .is_word   (is_word),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Independent reference using the simulator's own signed/unsigned division.
  task automatic ref_div(input logic [63:0] a, input logic [63:0] b, input logic s, input logic w,
                         output logic [63:0] q, output logic [63:0] r);
    logic [31:0] a32, b32, q32, r32;
    if (w) begin
      a32 = a[31:0];
      b32 = b[31:0];
      if (b32 == 32'd0) begin q32 = 32'hFFFF_FFFF; r32 = a32; end
      else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin q32 = a32; r32 = 32'd0; end
      else if (s) begin q32 = $signed(a32) / $signed(b32); r32 = $signed(a32) % $signed(b32); end
      else begin q32 = a32 / b32; r32 = a32 % b32; end
      q = {{32{q32[31]}}, q32};
      r = {{32{r32[31]}}, r32};
    end else begin
      if (b == 64'd0) begin q = '1; r = a; end
      else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin q = a; r = 64'd0; end
      else if (s) begin q = $signed(a) / $signed(b); r = $signed(a) % $signed(b); end
      else begin q = a / b; r = a % b; end
    end
  endtask

  // Issue one request, wait (bounded) for out_valid; consume it if out_ready is high.
  task automatic do_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                       input logic s, input logic w,
                       output logic [63:0] q, output logic [63:0] r, output int lat);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    dividend  = a;
    divisor   = b;
    is_signed = s;
    is_word   = w;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_out_valid"}, 64'(out_valid), 64'd1);
    q = quotient;
    r = remainder;
    if (out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic run_chk(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input logic s, input logic w,
                         input logic [63:0] eq, input logic [63:0] er, input int elat);
    logic [63:0] q, r;
    int lat;
    do_op(tag, a, b, s, w, q, r, lat);
    check({tag, "_quot"}, q, eq);
    check({tag, "_rem"}, r, er);
    if (elat > 0) check({tag, "_lat"}, 64'(lat), 64'(elat));
  endtask

  initial begin
    logic [63:0] q, r, eq, er, a, b, q0, r0;
    int lat;
    logic seen;

    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    dividend = '0; divisor = '0; is_signed = 1'b0; is_word = 1'b0;
    #12;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_quot", quotient, 64'd0);
    check("rst_rem", remainder, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic unsigned and signed operations
    run_chk("divu_100_7", 64'd100, 64'd7, 1'b0, 1'b0, 64'd14, 64'd2, LAT_D);
    run_chk("div_m7_2", -64'sd7, 64'd2, 1'b1, 1'b0, -64'sd3, -64'sd1, LAT_D);
    run_chk("rem_7_m2", 64'd7, -64'sd2, 1'b1, 1'b0, -64'sd3, 64'd1, LAT_D);
    run_chk("divw_min_1", 64'h0000_0000_8000_0000, 64'd1, 1'b1, 1'b1,
            64'hFFFF_FFFF_8000_0000, 64'd0, LAT_W);
    run_chk("divuw_ff_1", 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b1, '1, 64'd0, LAT_W);

    // Special cases
    run_chk("div0", 64'd5, 64'd0, 1'b0, 1'b0, '1, 64'd5, 2);
    run_chk("div_ovf", 64'h8000_0000_0000_0000, '1, 1'b1, 1'b0,
            64'h8000_0000_0000_0000, 64'd0, 2);
    run_chk("divw0_uw", 64'h1234_5678_8000_0001, 64'hFFFF_FFFF_0000_0000, 1'b0, 1'b1,
            '1, 64'hFFFF_FFFF_8000_0001, 2);

`ifdef YSYX_040729_DIV_EARLY_OUT_EN
    run_chk("divu_3_10", 64'd3, 64'd10, 1'b0, 1'b0, 64'd0, 64'd3, 3);
`else
    run_chk("divu_3_10", 64'd3, 64'd10, 1'b0, 1'b0, 64'd0, 64'd3, LAT_D);
`endif

    // Flush together with in_valid in IDLE: nothing is accepted
    dividend = 64'd5; divisor = 64'd0; is_signed = 1'b0; is_word = 1'b0;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("idle_flush_in_ready", 64'(in_ready), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("idle_flush_no_result", 64'(seen), 64'd0);

    // Result backpressure; a request offered in DONE must not be taken
    out_ready = 1'b0;
    do_op("bp", 64'd1000, 64'd33, 1'b0, 1'b0, q0, r0, lat);
    check("bp_quot", q0, 64'd30);
    check("bp_rem", r0, 64'd10);
    dividend = 64'd7; divisor = 64'd0; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_hold_quot", quotient, q0);
      check("bp_hold_rem", remainder, r0);
      check("bp_hold_valid", 64'(out_valid), 64'd1);
      check("bp_hold_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", 64'(out_valid), 64'd0);
    check("bp_release_in_ready", 64'(in_ready), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("bp_done_req_dropped", 64'(seen), 64'd0);

    // Flush in DONE together with out_ready
    out_ready = 1'b0;
    do_op("done_flush", 64'd5, 64'd0, 1'b0, 1'b0, q, r, lat);
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("done_flush_valid", 64'(out_valid), 64'd0);
    check("done_flush_in_ready", 64'(in_ready), 64'd1);

    // Flush in CALC cycle 20
    dividend = 64'd123456789; divisor = 64'd1000; is_signed = 1'b0; is_word = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("calc_flush_valid", 64'(out_valid), 64'd0);
    check("calc_flush_in_ready", 64'(in_ready), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("calc_flush_no_result", 64'(seen), 64'd0);
    run_chk("divu_9_3", 64'd9, 64'd3, 1'b0, 1'b0, 64'd3, 64'd0, LAT_D);

    // Asynchronous reset mid-CALC, between clock edges
    dividend = 64'hFFFF_0000_1234_5678; divisor = 64'd3; is_signed = 1'b0; is_word = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    check("arst_quot", quotient, 64'd0);
    check("arst_rem", remainder, 64'd0);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_chk("after_rst", 64'd1000, -64'sd7, 1'b1, 1'b0, -64'sd142, 64'd6, LAT_D);

    // Random operands against the reference model, all four modes
    for (int i = 0; i < 16; i++) begin
      a = {$urandom, $urandom};
      b = (i % 3 == 0) ? 64'($urandom_range(1, 100)) : {$urandom, $urandom};
      if (i % 4 == 1) b = {32'($urandom), 16'd0, 16'($urandom)} >> 20;
      if (i % 5 == 2) a = -a;
      ref_div(a, b, i[0], i[1], eq, er);
      run_chk("rand", a, b, i[0], i[1], eq, er, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
